// File: rtl/misr_pkg.sv
// Shared types, default polynomials and the MISR next-state function.
package misr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Widest signature the shared helper functions can handle.
   localparam int unsigned MAX_SIG_W = 64;

   localparam logic [7:0]  POLY_8  = 8'h1D;
   localparam logic [15:0] POLY_16 = 16'h1021;
   localparam logic [31:0] POLY_32 = 32'h04C11DB7;

   // Default feedback taps for a given signature width.
   function automatic logic [MAX_SIG_W-1:0] default_poly(input int unsigned width);
      case (width)
         8:       return MAX_SIG_W'(POLY_8);
         32:      return MAX_SIG_W'(POLY_32);
         default: return MAX_SIG_W'(POLY_16);
      endcase
   endfunction

   // One Galois MISR step on the low 'width' bits: shift left, fold in the
   // taps when the shifted-out MSB was set, then inject the lane data.
   function automatic logic [MAX_SIG_W-1:0] misr_next(
      input logic [MAX_SIG_W-1:0] sig,
      input logic [MAX_SIG_W-1:0] data,
      input logic [MAX_SIG_W-1:0] poly,
      input int unsigned          width
   );
      logic [MAX_SIG_W-1:0] mask;
      logic [MAX_SIG_W-1:0] res;
      mask = (width >= MAX_SIG_W) ? '1 : ((MAX_SIG_W'(1) << width) - MAX_SIG_W'(1));
      res  = (sig << 1) ^ data;
      if (((sig >> (width - 1)) & MAX_SIG_W'(1)) != '0) begin
         res = res ^ poly;
      end
      return res & mask;
   endfunction

endpackage

// File: rtl/misr_core.sv
// Signature register with synchronous seed load and per-beat update.
//  clk, rst    : clock, asynchronous active-high reset (loads SEED)
//  load        : reload SEED (wins over en)
//  en          : apply one MISR step with data
//  data        : zero-extended lane word injected per step
//  sig         : current signature
//  sig_next_c  : combinational post-update signature
module misr_core
   import misr_pkg::*;
#(
   parameter int unsigned       SIG_W = 16,
   parameter int unsigned       IN_W  = 8,
   parameter logic [SIG_W-1:0]  POLY  = SIG_W'(default_poly(SIG_W)),
   parameter logic [SIG_W-1:0]  SEED  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [IN_W-1:0]  data,
   output logic [SIG_W-1:0] sig,
   output logic [SIG_W-1:0] sig_next_c
);

   assign sig_next_c = SIG_W'(misr_next(MAX_SIG_W'(sig), MAX_SIG_W'(data),
                                        MAX_SIG_W'(POLY), SIG_W));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig <= SEED;
      end else if (load) begin
         sig <= SEED;
      end else if (en) begin
         sig <= sig_next_c;
      end
   end

endmodule

// File: rtl/misr_frame_checker.sv
// Passive MISR frame checker: compresses accepted beats of a window into a
// signature and compares it with a golden value at window end.
//  clk_i, reset_i     : clock, asynchronous active-high reset
//  clear_i            : synchronous abort back to IDLE with SEED reloaded
//  start_i            : arm a window (IDLE or DONE only)
//  valid_i, rdy_i     : a beat is valid_i && rdy_i
//  data_i             : NUM_CH lanes of DATA_W bits
//  golden_i           : expected signature, sampled with the last beat
//  busy_o, done_o     : window open / window closed
//  pass_o, fail_o     : result, only while done_o
//  beat_cnt_o         : beats accepted in the current window
//  signature_o        : current signature
module misr_frame_checker
   import misr_pkg::*;
#(
   parameter int unsigned       DATA_W    = 8,
   parameter int unsigned       NUM_CH    = 1,
   parameter int unsigned       SIG_W     = 16,
   parameter logic [SIG_W-1:0]  POLY      = SIG_W'(default_poly(SIG_W)),
   parameter logic [SIG_W-1:0]  SEED      = '0,
   parameter int unsigned       FRAME_LEN = 4096,
   parameter int unsigned       CNT_W     = $clog2(FRAME_LEN + 1)
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     clear_i,
   input  logic                     start_i,
   input  logic                     valid_i,
   input  logic                     rdy_i,
   input  logic [NUM_CH*DATA_W-1:0] data_i,
   input  logic [SIG_W-1:0]         golden_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     pass_o,
   output logic                     fail_o,
   output logic [CNT_W-1:0]         beat_cnt_o,
   output logic [SIG_W-1:0]         signature_o
);

   localparam int unsigned IN_W = NUM_CH * DATA_W;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   state_t           state;
   logic             beat_c;
   logic             load_c;
   logic             en_c;
   logic             match_c;
   logic [SIG_W-1:0] sig_next_c;

   assign beat_c  = valid_i && rdy_i;
   // Seed reload on abort or on an accepted arm; start in RUN is ignored.
   assign load_c  = clear_i || (start_i && (state != ST_RUN));
   assign en_c    = beat_c && (state == ST_RUN);
   assign match_c = (sig_next_c == golden_i);

   misr_core #(
      .SIG_W (SIG_W),
      .IN_W  (IN_W),
      .POLY  (POLY),
      .SEED  (SEED)
   ) u_core (
      .clk        (clk_i),
      .rst        (reset_i),
      .load       (load_c),
      .en         (en_c),
      .data       (data_i),
      .sig        (signature_o),
      .sig_next_c (sig_next_c)
   );

   // Window FSM, beat counter and registered result flags.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state      <= ST_IDLE;
         beat_cnt_o <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         pass_o     <= 1'b0;
         fail_o     <= 1'b0;
      end else if (clear_i) begin
         state      <= ST_IDLE;
         beat_cnt_o <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         pass_o     <= 1'b0;
         fail_o     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start_i) begin
                  state      <= ST_RUN;
                  beat_cnt_o <= '0;
                  busy_o     <= 1'b1;
                  done_o     <= 1'b0;
                  pass_o     <= 1'b0;
                  fail_o     <= 1'b0;
               end
            end
            ST_RUN: begin
               if (beat_c) begin
                  beat_cnt_o <= beat_cnt_o + CNT_W'(1);
                  if (beat_cnt_o == LAST_CNT) begin
                     // Result reflects the signature including this last beat.
                     state  <= ST_DONE;
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                     pass_o <= match_c;
                     fail_o <= !match_c;
                  end
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_o <= 1'b0;
               done_o <= 1'b0;
               pass_o <= 1'b0;
               fail_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_misr_frame_checker.sv
// Self-checking bench for misr_frame_checker across several parameter sets.
module tb_misr_frame_checker;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear;
   logic        start;
   logic        valid;
   logic        rdy;
   logic [15:0] data;
   logic [15:0] golden;

   int errors = 0;
   int checks = 0;

   // A: FRAME_LEN=4, SEED=0
   logic        busy_a, done_a, pass_a, fail_a;
   logic [2:0]  cnt_a;
   logic [15:0] sig_a;
   // B: SEED=8000, FRAME_LEN=2
   logic        busy_b, done_b, pass_b, fail_b;
   logic [1:0]  cnt_b;
   logic [15:0] sig_b;
   // C: two lanes, FRAME_LEN=1000
   logic        busy_c, done_c, pass_c, fail_c;
   logic [9:0]  cnt_c;
   logic [15:0] sig_c;
   // D: FRAME_LEN=1
   logic        busy_d, done_d, pass_d, fail_d;
   logic [0:0]  cnt_d;
   logic [15:0] sig_d;

   misr_frame_checker #(.DATA_W(8), .NUM_CH(1), .SIG_W(16), .POLY(16'h1021),
                        .SEED(16'h0000), .FRAME_LEN(4)) dut_a (
      .clk_i(clk), .reset_i(reset), .clear_i(clear), .start_i(start),
      .valid_i(valid), .rdy_i(rdy), .data_i(data[7:0]), .golden_i(golden),
      .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .fail_o(fail_a),
      .beat_cnt_o(cnt_a), .signature_o(sig_a));

   misr_frame_checker #(.DATA_W(8), .NUM_CH(1), .SIG_W(16), .POLY(16'h1021),
                        .SEED(16'h8000), .FRAME_LEN(2)) dut_b (
      .clk_i(clk), .reset_i(reset), .clear_i(clear), .start_i(start),
      .valid_i(valid), .rdy_i(rdy), .data_i(data[7:0]), .golden_i(golden),
      .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .fail_o(fail_b),
      .beat_cnt_o(cnt_b), .signature_o(sig_b));

   misr_frame_checker #(.DATA_W(8), .NUM_CH(2), .SIG_W(16), .POLY(16'h1021),
                        .SEED(16'h0000), .FRAME_LEN(1000)) dut_c (
      .clk_i(clk), .reset_i(reset), .clear_i(clear), .start_i(start),
      .valid_i(valid), .rdy_i(rdy), .data_i(data), .golden_i(golden),
      .busy_o(busy_c), .done_o(done_c), .pass_o(pass_c), .fail_o(fail_c),
      .beat_cnt_o(cnt_c), .signature_o(sig_c));

   misr_frame_checker #(.DATA_W(8), .NUM_CH(1), .SIG_W(16), .POLY(16'h1021),
                        .SEED(16'h0000), .FRAME_LEN(1)) dut_d (
      .clk_i(clk), .reset_i(reset), .clear_i(clear), .start_i(start),
      .valid_i(valid), .rdy_i(rdy), .data_i(data[7:0]), .golden_i(golden),
      .busy_o(busy_d), .done_o(done_d), .pass_o(pass_d), .fail_o(fail_d),
      .beat_cnt_o(cnt_d), .signature_o(sig_d));

   always #5 clk = ~clk;

   // Reference step: multiply by x modulo the 17-bit polynomial x^16+0x1021, add data.
   function automatic logic [15:0] ref_step(input logic [15:0] s, input logic [15:0] d);
      int unsigned v;
      v = 32'(s) * 2;
      if (v >= 65536) v = (v - 65536) ^ 32'h1021;
      return 16'(v) ^ d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      clear = 1'b0; start = 1'b0; valid = 1'b0; rdy = 1'b0;
      data = '0; golden = '0;
   endtask

   task automatic do_clear();
      clear = 1'b1; tick(); clear = 1'b0;
   endtask

   task automatic arm();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic send(input logic [15:0] d);
      valid = 1'b1; rdy = 1'b1; data = d; tick(); valid = 1'b0; rdy = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      tick(); tick();
      checks++;
      if ({busy_a, done_a, pass_a, fail_a, cnt_a, sig_a} !== 23'd0) begin
         errors++;
         $display("FAIL reset_a: got busy=%b done=%b pass=%b fail=%b cnt=%0d sig=%h want all zero",
                  busy_a, done_a, pass_a, fail_a, cnt_a, sig_a);
      end
      checks++;
      if (sig_b !== 16'h8000) begin
         errors++; $display("FAIL reset_seed_b: got %h want 8000", sig_b);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_step();
      do_clear(); arm();
      checks++;
      if (busy_a !== 1'b1 || cnt_a !== 3'd0) begin
         errors++; $display("FAIL arm_a: got busy=%b cnt=%0d want 1 0", busy_a, cnt_a);
      end
      send(16'h0001);
      checks++;
      if (sig_a !== 16'h0001) begin
         errors++; $display("FAIL step1: got %h want 0001", sig_a);
      end
      send(16'h0000);
      checks++;
      if (sig_a !== 16'h0002 || cnt_a !== 3'd2) begin
         errors++; $display("FAIL step2: got sig=%h cnt=%0d want 0002 2", sig_a, cnt_a);
      end
   endtask

   task automatic test_feedback();
      do_clear(); arm();
      send(16'h0000);
      checks++;
      if (sig_b !== 16'h1021 || done_b !== 1'b0) begin
         errors++; $display("FAIL feedback1: got sig=%h done=%b want 1021 0", sig_b, done_b);
      end
      golden = 16'h2042;
      send(16'h0000);
      checks++;
      if (sig_b !== 16'h2042 || done_b !== 1'b1 || pass_b !== 1'b1 || fail_b !== 1'b0) begin
         errors++;
         $display("FAIL feedback2: got sig=%h done=%b pass=%b fail=%b want 2042 1 1 0",
                  sig_b, done_b, pass_b, fail_b);
      end
      golden = '0;
   endtask

   task automatic test_window();
      logic [15:0] exp_sig;
      for (int pass_case = 1; pass_case >= 0; pass_case--) begin
         if (pass_case == 1) do_clear();
         arm();
         checks++;
         if (done_a !== 1'b0 || pass_a !== 1'b0 || fail_a !== 1'b0) begin
            errors++; $display("FAIL rearm_flags: got done=%b pass=%b fail=%b want 0 0 0",
                               done_a, pass_a, fail_a);
         end
         exp_sig = 16'h0000;
         for (int i = 1; i <= 4; i++) begin
            exp_sig = ref_step(exp_sig, 16'(i));
            if (i == 4) golden = (pass_case == 1) ? exp_sig : (exp_sig ^ 16'h0001);
            if (i == 4) begin
               checks++;
               if (done_a !== 1'b0 || pass_a !== 1'b0 || fail_a !== 1'b0) begin
                  errors++; $display("FAIL early_done: got done=%b pass=%b fail=%b want 0 0 0",
                                     done_a, pass_a, fail_a);
               end
            end
            send(16'(i));
         end
         golden = 16'hFFFF;
         checks++;
         if (sig_a !== exp_sig || cnt_a !== 3'd4 || done_a !== 1'b1 || busy_a !== 1'b0 ||
             pass_a !== 1'(pass_case) || fail_a !== 1'(1 - pass_case)) begin
            errors++;
            $display("FAIL window_%0d: got sig=%h cnt=%0d done=%b busy=%b pass=%b fail=%b want sig=%h cnt=4 done=1 busy=0 pass=%0d",
                     pass_case, sig_a, cnt_a, done_a, busy_a, pass_a, fail_a, exp_sig, pass_case);
         end
         // Golden changes after the last beat must not disturb the held result.
         tick();
         checks++;
         if (pass_a !== 1'(pass_case) || sig_a !== exp_sig) begin
            errors++; $display("FAIL window_hold_%0d: got pass=%b sig=%h want %0d %h",
                               pass_case, pass_a, sig_a, pass_case, exp_sig);
         end
      end
      golden = '0;
   endtask

   task automatic test_handshake();
      logic [15:0] exp_sig;
      do_clear();
      send(16'h00AB);
      checks++;
      if (sig_a !== 16'h0000 || cnt_a !== 3'd0 || busy_a !== 1'b0) begin
         errors++; $display("FAIL idle_beat: got sig=%h cnt=%0d busy=%b want 0000 0 0", sig_a, cnt_a, busy_a);
      end
      // Beat presented in the start cycle is ignored.
      start = 1'b1; valid = 1'b1; rdy = 1'b1; data = 16'h00FF;
      tick();
      start = 1'b0;
      rdy = 1'b0;
      for (int i = 0; i < 10; i++) begin
         data = 16'($urandom);
         tick();
      end
      checks++;
      if (sig_a !== 16'h0000 || cnt_a !== 3'd0) begin
         errors++; $display("FAIL no_rdy: got sig=%h cnt=%0d want 0000 0", sig_a, cnt_a);
      end
      valid = 1'b0; rdy = 1'b1; data = 16'h0033;
      tick(); tick();
      rdy = 1'b0;
      checks++;
      if (sig_a !== 16'h0000 || cnt_a !== 3'd0) begin
         errors++; $display("FAIL no_valid: got sig=%h cnt=%0d want 0000 0", sig_a, cnt_a);
      end
      send(16'h0005);
      // Start during RUN must not restart; the beat in that cycle still counts.
      start = 1'b1;
      send(16'h0007);
      start = 1'b0;
      exp_sig = ref_step(ref_step(16'h0000, 16'h0005), 16'h0007);
      checks++;
      if (sig_a !== exp_sig || cnt_a !== 3'd2 || busy_a !== 1'b1) begin
         errors++; $display("FAIL start_in_run: got sig=%h cnt=%0d busy=%b want %h 2 1",
                            sig_a, cnt_a, busy_a, exp_sig);
      end
      send(16'h0011); send(16'h0022);
      exp_sig = ref_step(ref_step(exp_sig, 16'h0011), 16'h0022);
      send(16'h0099); send(16'h0044);
      checks++;
      if (sig_a !== exp_sig || cnt_a !== 3'd4 || done_a !== 1'b1) begin
         errors++; $display("FAIL done_beat: got sig=%h cnt=%0d done=%b want %h 4 1",
                            sig_a, cnt_a, done_a, exp_sig);
      end
   endtask

   task automatic test_abort();
      do_clear(); arm();
      send(16'h0012); send(16'h0034);
      checks++;
      if (cnt_a !== 3'd2) begin
         errors++; $display("FAIL abort_pre: got cnt=%0d want 2", cnt_a);
      end
      do_clear();
      checks++;
      if (sig_a !== 16'h0000 || cnt_a !== 3'd0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
         errors++; $display("FAIL clear_mid: got sig=%h cnt=%0d busy=%b done=%b want 0000 0 0 0",
                            sig_a, cnt_a, busy_a, done_a);
      end
      arm();
      send(16'h0056); send(16'h0078);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (sig_a !== 16'h0000 || cnt_a !== 3'd0 || busy_a !== 1'b0 || sig_b !== 16'h8000) begin
         errors++; $display("FAIL async_reset: got sig=%h cnt=%0d busy=%b sig_b=%h want 0000 0 0 8000",
                            sig_a, cnt_a, busy_a, sig_b);
      end
      tick();
      reset = 1'b0;
      send(16'h0001);
      checks++;
      if (busy_a !== 1'b0 || sig_a !== 16'h0000) begin
         errors++; $display("FAIL post_reset_idle: got busy=%b sig=%h want 0 0000", busy_a, sig_a);
      end
   endtask

   task automatic test_frame_len_one();
      logic [15:0] d;
      for (int k = 0; k < 2; k++) begin
         d = 16'($urandom_range(0, 255));
         do_clear(); arm();
         golden = (k == 0) ? d : (d ^ 16'h0080);
         send(d);
         checks++;
         if (sig_d !== d || cnt_d !== 1'b1 || done_d !== 1'b1 ||
             pass_d !== (k == 0) || fail_d !== (k != 0)) begin
            errors++; $display("FAIL frame_len_one_%0d: got sig=%h cnt=%0d done=%b pass=%b fail=%b want %h 1 1 %0d",
                               k, sig_d, cnt_d, done_d, pass_d, fail_d, d, (k == 0));
         end
      end
      golden = '0;
   endtask

   task automatic test_multilane();
      logic [15:0] words [1000];
      logic [15:0] exp_sig;
      int idx;
      int cycles;
      logic v;
      logic r;
      do_clear(); arm();
      send(16'hA55A);
      checks++;
      if (sig_c !== 16'hA55A) begin
         errors++; $display("FAIL multilane_first: got %h want a55a", sig_c);
      end
      exp_sig = 16'h0000;
      for (int i = 0; i < 1000; i++) begin
         words[i] = 16'($urandom);
         exp_sig = ref_step(exp_sig, words[i]);
      end
      do_clear(); arm();
      golden = exp_sig;
      exp_sig = 16'h0000;
      idx = 0;
      cycles = 0;
      while (idx < 1000 && cycles < 5000) begin
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 3) != 0);
         valid = v; rdy = r; data = words[idx];
         tick();
         cycles++;
         if (v && r) begin
            exp_sig = ref_step(exp_sig, words[idx]);
            idx++;
         end
         checks++;
         if (sig_c !== exp_sig || cnt_c !== 10'(idx)) begin
            errors++; $display("FAIL random_frame beat %0d: got sig=%h cnt=%0d want %h %0d",
                               idx, sig_c, cnt_c, exp_sig, idx);
         end
      end
      valid = 1'b0; rdy = 1'b0;
      checks++;
      if (idx < 1000) begin
         errors++; $display("FAIL random_frame_timeout: got %0d beats want 1000", idx);
      end
      checks++;
      if (done_c !== 1'b1 || pass_c !== 1'b1 || fail_c !== 1'b0 || busy_c !== 1'b0) begin
         errors++; $display("FAIL random_frame_result: got done=%b pass=%b fail=%b busy=%b want 1 1 0 0",
                            done_c, pass_c, fail_c, busy_c);
      end
      golden = '0;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_single_step();
      test_feedback();
      test_window();
      test_handshake();
      test_abort();
      test_frame_len_one();
      test_multilane();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
